md_sequencer: RTL and testbench

- Multi-cycle multiply/divide controller in the EX stage, alongside the single-cycle ALU.
- Latches operands on a start strobe and counts a fixed busy latency per operation.
- Commits the results to its own HI/LO registers and drives busy for the hazard unit to stall MD-dependent instructions.
- Also services single-cycle MTHI/MTLO writes.

---
 rtl/md_pkg.sv | 24 ++
 rtl/md_sequencer_if.sv | 12 +
 rtl/md_arith.sv | 40 ++++
 rtl/md_sequencer.sv | 61 ++++++
 tb/tb_md_sequencer.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared opcodes, FSM states and default latencies for the MD unit (MD_MADD_EN enables MADD/MSUB)
package md_pkg;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    typedef enum logic {IDLE, RUN} state_t;
    function automatic logic is_div(input logic [2:0] op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction
    function automatic logic is_multi(input logic [2:0] op);
`ifdef MD_MADD_EN
        return op != OP_MTHI && op != OP_MTLO;
`else
        return op[2] == 1'b0;
`endif
    endfunction
endpackage

// File: rtl/md_sequencer_if.sv
// md_sequencer_if: EX-stage request (start/md_op/a/b) and status (busy/hi/lo) bundle
interface md_sequencer_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, md_op, a, b, input busy, hi, lo);
    modport slave  (input start, md_op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational HI/LO result generator; ports op/a/b/acc in, hi_next/lo_next/div_by_zero out (MD_MADD_EN adds MADD/MSUB)
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] acc,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next,
    output logic        div_by_zero
);
    logic [63:0] prod_s, prod_u, ext;
    logic [31:0] mag_a, mag_b, div_s, div_u, q_m, r_m, q_s, r_s, q_u, r_u;
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'b0, a} * {32'b0, b};
        // signed divide via magnitudes avoids the INT_MIN / -1 overflow trap
        mag_a = a[31] ? -a : a;
        mag_b = b[31] ? -b : b;
        div_s = mag_b == 32'b0 ? 32'd1 : mag_b;
        div_u = b == 32'b0 ? 32'd1 : b;
        q_m = mag_a / div_s;
        r_m = mag_a % div_s;
        q_s = (a[31] ^ b[31]) ? -q_m : q_m;
        r_s = a[31] ? -r_m : r_m;
        q_u = a / div_u;
        r_u = a % div_u;
        div_by_zero = b == 32'b0 && is_div(op);
`ifdef MD_MADD_EN
        ext = op == OP_MADD ? acc + prod_s : op == OP_MSUB ? acc - prod_s : acc;
`else
        ext = acc;
`endif
        {hi_next, lo_next} = op == OP_MULT  ? prod_s :
                             op == OP_MULTU ? prod_u :
                             op == OP_DIV   ? {r_s, q_s} :
                             op == OP_DIVU  ? {r_u, q_u} : ext;
    end
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle MD controller; clk/reset plus slave bus (start/md_op/a/b in, busy/hi/lo out); MD_MADD_EN enables MADD/MSUB
module md_sequencer
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
    input logic clk,
    input logic reset,
    md_sequencer_if.slave bus
);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, hi_nx, lo_nx;
    logic        dbz, launch, done, idle_wr;
    md_arith u_arith (
        .op(op_q), .a(a_q), .b(b_q), .acc({hi_q, lo_q}),
        .hi_next(hi_nx), .lo_next(lo_nx), .div_by_zero(dbz)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
    always_comb begin
        idle_wr = state_q == IDLE && bus.start;
        launch  = idle_wr && is_multi(bus.md_op);
        done    = state_q == RUN && cnt_q == 4'd0;
        state_d = launch ? RUN : done ? IDLE : state_q;
    end
    always_comb begin
        op_d  = launch ? bus.md_op : op_q;
        a_d   = launch ? bus.a : a_q;
        b_d   = launch ? bus.b : b_q;
        cnt_d = launch ? (is_div(bus.md_op) ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1)) :
                (state_q == RUN && !done) ? cnt_q - 4'd1 : cnt_q;
        // a divide by zero still spends its full latency but leaves HI/LO alone
        hi_d  = (done && !dbz) ? hi_nx : (idle_wr && bus.md_op == OP_MTHI) ? bus.a : hi_q;
        lo_d  = (done && !dbz) ? lo_nx : (idle_wr && bus.md_op == OP_MTLO) ? bus.a : lo_q;
    end
    always_comb begin
        bus.busy = state_q == RUN;
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed self-checking bench for md_sequencer
module tb_md_sequencer;
    import md_pkg::*;
    logic clk = 1'b0;
    logic reset;
    int total = 0;
    int bad = 0;
    md_sequencer_if bus();
    md_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.a = a;
        bus.b = b;
        step();
        bus.start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        issue(op, a, b);
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.md_op = 3'b0;
        bus.a = '0;
        bus.b = '0;
        step();
        step();
        reset = 1'b0;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
    endtask

    task automatic test_mult();
        int n;
        run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, n);
        chk("mult_cycles", 32'(n), 32'd5);
        chk("mult_hi", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo, 32'hFFFFFFFA);
    endtask

    task automatic test_div();
        logic [2:0]  ops[5] = '{OP_DIV, OP_DIV, OP_DIV, OP_DIVU, OP_DIVU};
        logic [31:0] as[5]  = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd100, 32'hFFFFFFF9};
        logic [31:0] bs[5]  = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7, 32'd2};
        logic [31:0] qs[5]  = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'd14, 32'h7FFFFFFC};
        logic [31:0] rs[5]  = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'd2, 32'd1};
        int n;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], n);
            chk($sformatf("div%0d_cycles", i), 32'(n), 32'd10);
            chk($sformatf("div%0d_lo", i), bus.lo, qs[i]);
            chk($sformatf("div%0d_hi", i), bus.hi, rs[i]);
        end
    endtask

    task automatic test_mt();
        issue(OP_MTHI, 32'hDEADBEEF, 32'd0);
        chk("mthi_hi", bus.hi, 32'hDEADBEEF);
        chk("mthi_busy", 32'(bus.busy), 32'd0);
        issue(OP_MTLO, 32'h1234, 32'd0);
        chk("mtlo_lo", bus.lo, 32'h1234);
        chk("mtlo_hi", bus.hi, 32'hDEADBEEF);
        chk("mtlo_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic test_div_zero();
        int n;
        issue(OP_MTHI, 32'h11, 32'd0);
        issue(OP_MTLO, 32'h22, 32'd0);
        run_op(OP_DIVU, 32'd100, 32'd0, n);
        chk("dbz_cycles", 32'(n), 32'd10);
        chk("dbz_hi", bus.hi, 32'h11);
        chk("dbz_lo", bus.lo, 32'h22);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        while (bus.busy && n < 40) begin
            n++;
            bus.a = $urandom;
            bus.b = $urandom;
            bus.start = n == 2;
            bus.md_op = OP_DIV;
            step();
        end
        bus.start = 1'b0;
        chk("b2b_cycles", 32'(n), 32'd5);
        chk("b2b_hi", bus.hi, 32'hFFFFFFFE);
        chk("b2b_lo", bus.lo, 32'h00000001);
        step();
        chk("b2b_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic test_reset_mid();
        int late = 0;
        issue(OP_DIV, 32'd100, 32'd3);
        for (int i = 1; i < 4; i++) step();
        chk("rmid_busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid_busy", 32'(bus.busy), 32'd0);
        chk("rmid_hi", bus.hi, 32'd0);
        chk("rmid_lo", bus.lo, 32'd0);
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.busy || bus.hi != 0 || bus.lo != 0) late++;
        end
        chk("rmid_no_commit", 32'(late), 32'd0);
    endtask

    task automatic test_madd();
`ifdef MD_MADD_EN
        int n;
        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'd10, 32'd0);
        run_op(OP_MADD, 32'd3, 32'd4, n);
        chk("madd_cycles", 32'(n), 32'd5);
        chk("madd_hi", bus.hi, 32'd0);
        chk("madd_lo", bus.lo, 32'd22);
        run_op(OP_MSUB, 32'd2, 32'd20, n);
        chk("msub_cycles", 32'(n), 32'd5);
        chk("msub_hi", bus.hi, 32'hFFFFFFFF);
        chk("msub_lo", bus.lo, 32'hFFFFFFEE);
`else
        issue(OP_MTHI, 32'h55, 32'd0);
        issue(OP_MTLO, 32'h66, 32'd0);
        issue(OP_MADD, 32'd3, 32'd4);
        chk("madd_noop_busy", 32'(bus.busy), 32'd0);
        issue(OP_MSUB, 32'd2, 32'd20);
        chk("msub_noop_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 6; i++) step();
        chk("noop_hi", bus.hi, 32'h55);
        chk("noop_lo", bus.lo, 32'h66);
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_madd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
